alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and issue sequencer that shares the single combinational `alu` between two requesters, e.g. the execute stage and the address/branch-compare unit. It accepts operations over valid/ready handshakes, registers one operation into an issue stage, drives the ALU from that register, and returns each result into a one-entry response buffer owned by the requester. Sustained throughput is one operation per cycle with backpressure on each response port.

## Interface
- `WORD_SIZE`, 32, operand/result width; passed through to the ALU.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `p0_req_valid`, `p1_req_valid`  input  1  request present on port i.
- `p0_req_ready`, `p1_req_ready`  output  1  request accepted this cycle when valid & ready.
- `p0_req_opcode`, `p1_req_opcode`  input  4  ALU opcode (`ALU_*` codes from `defines.vh`).
- `p0_req_a`, `p1_req_a`, `p0_req_b`, `p1_req_b`  input  WORD_SIZE  operands; shift amount is in `a`, shifted value in `b`.
- `p0_rsp_valid`, `p1_rsp_valid`  output  1  response buffer i holds a result.
- `p0_rsp_ready`, `p1_rsp_ready`  input  1  requester i consumes the response.
- `p0_rsp_result`, `p1_rsp_result`  output  WORD_SIZE  buffered result.
- `p0_rsp_err`, `p1_rsp_err`  output  1  illegal opcode flag; exists only with `ALU_ARB_OPCHECK_EN`.
- `alu_opcode`  output  4  to ALU, issue-stage opcode.
- `alu_a`, `alu_b`  output  WORD_SIZE  to ALU, issue-stage operands.
- `alu_result`  input  WORD_SIZE  from ALU.

## Operation
- State: issue stage S1 (`s1_valid`, opcode, a, b, `s1_id`); response buffers R0/R1 (valid, result, err); round-robin pointer `last` (id of the last grant).
- S1 advance: `s1_go = s1_valid & (~Ri.valid | pi_rsp_ready)` with i = `s1_id`. On `s1_go`, Ri captures `alu_result` and sets valid.
- Accept condition: `can_accept = ~s1_valid | s1_go`.
- Grant: only one port valid → that port; both valid → port != `last`. `pi_req_ready = can_accept & grant_i`. Ready may depend on valid; at most one ready high per cycle.
- On accept: S1 loads the granted port's opcode/a/b, `s1_id` = i, `s1_valid` = 1, `last` = i. Without an accept, `s1_valid` clears on `s1_go`.
- `last` changes only on accept; an idle cycle keeps priority unchanged.
- Response pop: `pi_rsp_valid & pi_rsp_ready` clears Ri unless S1 writes Ri in the same cycle, in which case Ri takes the new result and stays valid.
- `alu_opcode`/`alu_a`/`alu_b` always reflect S1 contents, including when `s1_valid` = 0. Zero after reset.
- Operands are never modified or sign-processed; arithmetic semantics belong to the ALU.

## Timing
- Reset (async assert, sync-released by the SoC): `s1_valid`=0, R0/R1 valid=0, results=0, err=0, `last`=1 (port 0 wins the first tie). S1 opcode/a/b are 0, so `alu_*` outputs are 0. Both `req_ready` outputs are low unless the corresponding valid is high.
- Latency: request accepted at edge N → S1 valid during cycle N..N+1 → `pi_rsp_valid` high after edge N+1, i.e. one cycle after acceptance.
- Throughput: 1 op/cycle when the response consumers hold ready high.
- Stall: if Ri is full and `pi_rsp_ready`=0, S1 holds, and both `req_ready` outputs are 0, even for the other port (in-order single issue stage).
- Reset mid-operation discards S1 and both buffers; no response is produced for in-flight requests.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined: S1 decodes its opcode against AND, OR, ADD, ADDU, SUB, SUBU, SLT, NOR, SLL, SRA, SRL. For an illegal opcode, S1 forces `alu_opcode` to `ALU_OR` with `alu_a`=`alu_b`=0, stores result 0 with `rsp_err`=1, and preserves timing. For a legal opcode, `rsp_err`=0.
- Undefined: no decode and no `*_rsp_err` ports. The opcode passes through unchanged and an illegal code yields the ALU's X result.

## Test plan
- Single op: p0 ADDU a=5 b=7 → `p0_req_ready`=1 at accept; `p0_rsp_valid`=1 next cycle with result 12. `p1_rsp_valid` stays 0.
- Tie and fairness: both ports valid continuously, p0 SUBU 10,3 and p1 SLL 4,1 → grants alternate p0,p1,p0,… starting with p0. Results are 7 and 16, one result per cycle.
- Backpressure: `p0_rsp_ready`=0 with R0 full and S1 holding a p0 op → both `req_ready` outputs are 0 and S1 and R0 hold their values. Raise `p0_rsp_ready` → the held result is delivered next cycle.
- Pop and fill in the same cycle: R0 full, `p0_rsp_ready`=1, and S1 targets p0 → R0 stays valid with the new result and no bubble appears.
- Reset mid-flight: assert `rst_n`=0 with S1 and R1 valid → all rsp_valid go to 0 immediately (asynchronous). After release, a tie grants p0.
- Opcode check (with macro): p1 opcode 4'hF a=1 b=1 → `p1_rsp_result`=0 and `p1_rsp_err`=1. A following p1 ADD 1,1 → result 2 with err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and single issue stage in front of a
// shared combinational ALU, with a one-entry response buffer per requester.
// Optional feature macro: ALU_ARB_OPCHECK_EN (illegal-opcode decode and *_rsp_err).
// The ALU opcode encoding is assumed to be the ALU_* set shared with the ALU.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req_valid,
  output logic                 p0_req_ready,
  input  logic [3:0]           p0_req_opcode,
  input  logic [WORD_SIZE-1:0] p0_req_a,
  input  logic [WORD_SIZE-1:0] p0_req_b,
  input  logic                 p1_req_valid,
  output logic                 p1_req_ready,
  input  logic [3:0]           p1_req_opcode,
  input  logic [WORD_SIZE-1:0] p1_req_a,
  input  logic [WORD_SIZE-1:0] p1_req_b,
  output logic                 p0_rsp_valid,
  input  logic                 p0_rsp_ready,
  output logic [WORD_SIZE-1:0] p0_rsp_result,
  output logic                 p1_rsp_valid,
  input  logic                 p1_rsp_ready,
  output logic [WORD_SIZE-1:0] p1_rsp_result,
`ifdef ALU_ARB_OPCHECK_EN
  output logic                 p0_rsp_err,
  output logic                 p1_rsp_err,
`endif
  output logic [3:0]           alu_opcode,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_result
);

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_ADDU = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_SUBU = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;

  function automatic logic op_legal(input logic [3:0] op);
    unique case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
      ALU_SLT, ALU_NOR, ALU_SLL, ALU_SRA, ALU_SRL: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  endfunction
`endif

  // Issue stage
  logic                 s1_valid_q;
  logic                 s1_id_q;
  logic [3:0]           s1_op_q;
  logic [WORD_SIZE-1:0] s1_a_q;
  logic [WORD_SIZE-1:0] s1_b_q;
  // Response buffers
  logic                 r0_valid_q;
  logic                 r1_valid_q;
  logic [WORD_SIZE-1:0] r0_result_q;
  logic [WORD_SIZE-1:0] r1_result_q;
  // Id of the last granted port; 1 after reset so port 0 wins the first tie
  logic                 last_q;

  logic                 gnt0;
  logic                 gnt1;
  logic                 rsp_free;
  logic                 s1_go;
  logic                 can_accept;
  logic                 accept;
  logic [3:0]           sel_op;
  logic [WORD_SIZE-1:0] sel_a;
  logic [WORD_SIZE-1:0] sel_b;
  logic [3:0]           load_op;
  logic [WORD_SIZE-1:0] load_a;
  logic [WORD_SIZE-1:0] load_b;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 wr0;
  logic                 wr1;

`ifdef ALU_ARB_OPCHECK_EN
  logic                 s1_err_q;
  logic                 r0_err_q;
  logic                 r1_err_q;
  logic                 load_err;
`endif

  // Grant, stage-advance and request-ready logic
  always_comb begin
    gnt0       = p0_req_valid & (~p1_req_valid | last_q);
    gnt1       = p1_req_valid & (~p0_req_valid | ~last_q);
    rsp_free   = s1_id_q ? (~r1_valid_q | p1_rsp_ready) : (~r0_valid_q | p0_rsp_ready);
    s1_go      = s1_valid_q & rsp_free;
    // A full buffer for the issuing port blocks both ports: single in-order stage
    can_accept = ~s1_valid_q | s1_go;
    p0_req_ready = can_accept & gnt0;
    p1_req_ready = can_accept & gnt1;
    accept     = p0_req_ready | p1_req_ready;
    wr0        = s1_go & ~s1_id_q;
    wr1        = s1_go & s1_id_q;
    sel_op     = gnt1 ? p1_req_opcode : p0_req_opcode;
    sel_a      = gnt1 ? p1_req_a : p0_req_a;
    sel_b      = gnt1 ? p1_req_b : p0_req_b;
  end

  // Issue-stage load values, with illegal opcodes neutralised when checking is on
  always_comb begin
    load_op = sel_op;
    load_a  = sel_a;
    load_b  = sel_b;
`ifdef ALU_ARB_OPCHECK_EN
    load_err = ~op_legal(sel_op);
    if (load_err) begin
      load_op = ALU_OR;
      load_a  = '0;
      load_b  = '0;
    end
`endif
  end

  // Result written into the response buffer on stage advance
  always_comb begin
    wr_data = alu_result;
`ifdef ALU_ARB_OPCHECK_EN
    if (s1_err_q) wr_data = '0;
`endif
  end

  // Issue stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      last_q     <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
      s1_err_q   <= 1'b0;
`endif
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_id_q    <= gnt1;
      s1_op_q    <= load_op;
      s1_a_q     <= load_a;
      s1_b_q     <= load_b;
      last_q     <= gnt1;
`ifdef ALU_ARB_OPCHECK_EN
      s1_err_q   <= load_err;
`endif
    end else if (s1_go) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Response buffer 0: a same-cycle fill wins over a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_valid_q  <= 1'b0;
      r0_result_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      r0_err_q    <= 1'b0;
`endif
    end else if (wr0) begin
      r0_valid_q  <= 1'b1;
      r0_result_q <= wr_data;
`ifdef ALU_ARB_OPCHECK_EN
      r0_err_q    <= s1_err_q;
`endif
    end else if (r0_valid_q && p0_rsp_ready) begin
      r0_valid_q  <= 1'b0;
    end
  end

  // Response buffer 1: a same-cycle fill wins over a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid_q  <= 1'b0;
      r1_result_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      r1_err_q    <= 1'b0;
`endif
    end else if (wr1) begin
      r1_valid_q  <= 1'b1;
      r1_result_q <= wr_data;
`ifdef ALU_ARB_OPCHECK_EN
      r1_err_q    <= s1_err_q;
`endif
    end else if (r1_valid_q && p1_rsp_ready) begin
      r1_valid_q  <= 1'b0;
    end
  end

  // Output drive: ALU always sees the issue-stage registers
  always_comb begin
    alu_opcode    = s1_op_q;
    alu_a         = s1_a_q;
    alu_b         = s1_b_q;
    p0_rsp_valid  = r0_valid_q;
    p1_rsp_valid  = r1_valid_q;
    p0_rsp_result = r0_result_q;
    p1_rsp_result = r1_result_q;
`ifdef ALU_ARB_OPCHECK_EN
    p0_rsp_err    = r0_err_q;
    p1_rsp_err    = r1_err_q;
`endif
  end

endmodule
